// File: rtl/data_mem_ws_if.sv
`timescale 1ns/1ps
// MEM-stage request/response bundle between the pipeline (master) and the
// wait-stated data memory (slave).
interface data_mem_ws_if;
    logic        Mem_Read_M;
    logic        Mem_Write_M;
    logic [31:0] ALU_Result_M;
    logic [31:0] Write_Data_M;
    logic [1:0]  data_size_M;
    logic        unsigned_M;
    logic [31:0] Read_Data_M;
    logic        Stall_Mem;
    logic        Mem_Ack;
    logic        Misalign_M;

    modport master (
        output Mem_Read_M,
        output Mem_Write_M,
        output ALU_Result_M,
        output Write_Data_M,
        output data_size_M,
        output unsigned_M,
        input  Read_Data_M,
        input  Stall_Mem,
        input  Mem_Ack,
        input  Misalign_M
    );

    modport slave (
        input  Mem_Read_M,
        input  Mem_Write_M,
        input  ALU_Result_M,
        input  Write_Data_M,
        input  data_size_M,
        input  unsigned_M,
        output Read_Data_M,
        output Stall_Mem,
        output Mem_Ack,
        output Misalign_M
    );
endinterface

// File: rtl/data_mem_ws.sv
`timescale 1ns/1ps
// Byte-addressed big-endian data memory with a fixed number of wait states and
// a stall handshake toward the MEM stage; misaligned requests never touch it.
module data_mem_ws #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    data_mem_ws_if.slave bus
);
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic                   wr_q, wr_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [7:0]             mem_q [DEPTH];

    logic                   req;
    logic                   is_byte;
    logic                   is_half;
    logic                   misaligned;
    logic                   accept;
    logic [ADDR_W-1:0]      req_addr;
    logic                   unused_addr_hi;

    logic [3:0][ADDR_W-1:0] baddr;
    logic [3:0][7:0]        rbyte;
    logic [3:0][7:0]        wbyte;
    logic [3:0]             we;
    logic [31:0]            load_val;
    logic                   commit;
    logic                   stall;
    logic                   ack;

    // Request decode, evaluated on the live bus (only meaningful in IDLE)
    assign req            = bus.Mem_Read_M | bus.Mem_Write_M;
    assign req_addr       = bus.ALU_Result_M[ADDR_W-1:0];
    assign unused_addr_hi = ^bus.ALU_Result_M[31:ADDR_W];
    assign is_byte        = (bus.data_size_M == 2'b01);
    assign is_half        = (bus.data_size_M == 2'b10);
    assign misaligned     = (is_half && req_addr[0]) ||
                            (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
    assign accept         = (state_q == ST_IDLE) && req && !misaligned;

    // Byte lanes: lane k is address+k, wrapping modulo the array depth
    always_comb begin
        baddr = '0;
        rbyte = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            baddr[k] = addr_q + ADDR_W'(k);
            rbyte[k] = mem_q[baddr[k]];
        end
    end

    always_comb begin
        load_val = '0;
        case (size_q)
            2'b01: begin
                load_val = uns_q ? {24'h0, rbyte[0]}
                                 : {{24{rbyte[0][7]}}, rbyte[0]};
            end
            2'b10: begin
                load_val = uns_q ? {16'h0, rbyte[0], rbyte[1]}
                                 : {{16{rbyte[0][7]}}, rbyte[0], rbyte[1]};
            end
            default: begin
                load_val = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
            end
        endcase
    end

    // Store data is right-aligned; the lowest lane receives the MSB
    always_comb begin
        we    = '0;
        wbyte = '0;
        if (commit && wr_q && !rst) begin
            case (size_q)
                2'b01: begin
                    we[0]    = 1'b1;
                    wbyte[0] = wdata_q[7:0];
                end
                2'b10: begin
                    we[1:0]  = 2'b11;
                    wbyte[0] = wdata_q[15:8];
                    wbyte[1] = wdata_q[7:0];
                end
                default: begin
                    we       = '1;
                    wbyte[0] = wdata_q[31:24];
                    wbyte[1] = wdata_q[23:16];
                    wbyte[2] = wdata_q[15:8];
                    wbyte[3] = wdata_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem_q[baddr[k]] <= wbyte[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        stall   = 1'b0;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = bus.Write_Data_M;
                    size_d  = bus.data_size_M;
                    uns_d   = bus.unsigned_M;
                    wr_d    = bus.Mem_Write_M;
                    cnt_d   = CNT_LOAD;
                    stall   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.Read_Data_M = rdata_q;
    assign bus.Stall_Mem   = stall;
    assign bus.Mem_Ack     = ack;
    assign bus.Misalign_M  = req && misaligned && (state_q == ST_IDLE);

endmodule

// File: doc/data_mem_ws.md
# data_mem_ws

Parametrised, byte-addressed, big-endian data memory for the MEM stage, with a configurable number of wait states and a stall handshake toward the pipeline. Each load or store holds the pipeline for a fixed, parameter-set number of cycles, then commits. Byte/half/word accesses support signed or unsigned load extension. Misaligned accesses are flagged and never touch memory.

## Interface
- ADDR_W, 10: byte-address width; depth = 2**ADDR_W bytes.
- WAIT_CYCLES, 2: wait states per access; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Mem_Read_M  in  1  load request.
- Mem_Write_M  in  1  store request; has priority if asserted together with Mem_Read_M.
- ALU_Result_M  in  32  byte address; bits above ADDR_W-1 ignored (wrap).
- Write_Data_M  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- data_size_M  in  2  01 byte, 10 half, 00/11 word.
- unsigned_M  in  1  1 = zero-extend byte/half loads, 0 = sign-extend.
- Read_Data_M  out  32  registered load result.
- Stall_Mem  out  1  hold the pipeline (combinational).
- Mem_Ack  out  1  one-cycle pulse: access complete.
- Misalign_M  out  1  misaligned request flag (combinational).

## Operation
- Big endian: byte at address A is the MSB of a half or word starting at A.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Misalign_M = request && misaligned && state==IDLE.
- A misaligned request causes no access, no stall and no state change.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on an aligned request, latch addr, data, size, unsigned, and op (write if Mem_Write_M, else read). Load counter = WAIT_CYCLES-1, then go to WAIT.
- WAIT: decrement counter. When counter==0, commit and go to DONE.
- Commit, store: write 1, 2 or 4 bytes from the latched address (address+k wraps modulo depth).
- Commit, load: assemble bytes big-endian, extend per the latched unsigned flag, and register into Read_Data_M.
- DONE: Mem_Ack=1; go to IDLE unconditionally.
- Stall_Mem = (IDLE && aligned request) || WAIT.
- Stall_Mem is low in DONE, so the pipeline advances at the end of the DONE cycle.
- Read_Data_M changes only on a load commit. It holds its value across stores, idles and misaligned requests.
- Memory contents are not initialised or cleared by reset.

## Timing
- Request first seen in IDLE at cycle T: Stall_Mem is high for cycles T..T+WAIT_CYCLES.
- Commit occurs at the rising edge that ends cycle T+WAIT_CYCLES.
- DONE at cycle T+WAIT_CYCLES+1: Mem_Ack=1, Stall_Mem=0, Read_Data_M valid.
- Total occupancy per access is WAIT_CYCLES+2 cycles. The next request is sampled in IDLE at T+WAIT_CYCLES+2.
- Request inputs are ignored outside IDLE; the latched copies are used.
- Reset values: state IDLE, counter 0, Read_Data_M 0, Stall_Mem 0, Mem_Ack 0, Misalign_M 0.
- Reset during WAIT: a pending store is discarded (memory unchanged) and a pending load produces no data.
- Reset during DONE: Mem_Ack drops immediately.
- Simultaneous read and write: handled as a store only; Read_Data_M unchanged.
- WAIT_CYCLES=1: WAIT lasts exactly one cycle.

## Test plan
- Word store 0xDEADBEEF at 0x010, then word load from 0x010 -> bytes 0x010..0x013 = DE,AD,BE,EF; Read_Data_M=0xDEADBEEF at Mem_Ack.
- Byte 0x80 at 0x020: lb (unsigned_M=0) -> 0xFFFFFF80; lbu -> 0x00000080. Half 0x8001 at 0x022: lh -> 0xFFFF8001; lhu -> 0x00008001.
- Half load at 0x021 and word load at 0x022 -> Misalign_M=1 in that cycle, Stall_Mem=0, Mem_Ack never pulses, Read_Data_M unchanged.
- WAIT_CYCLES=3, load at cycle T -> Stall_Mem high exactly T..T+3; Mem_Ack a single pulse at T+4.
- Store word 0x11223344 to 0x040 (prior content 0), assert rst in the second WAIT cycle -> 0x040..0x043 remain 0; outputs at reset values; next request accepted normally.
- Word store 0xA1B2C3D4 at address 2**ADDR_W+4 -> lands at 0x004..0x007; word load at 0x004 returns 0xA1B2C3D4.
